// File: rtl/gpmc_pkg.sv
// rtl/gpmc_pkg.sv - shared GPMC bus types, widths and default phase lengths
package gpmc_pkg;
    localparam int GPMC_AW       = 16;
    localparam int GPMC_DW       = 16;
    localparam int GPMC_ADV_CYC  = 2;
    localparam int GPMC_ACC_CYC  = 4;
    localparam int GPMC_HOLD_CYC = 1;

    typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, HOLD} gpmc_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/gpmc_phase_cnt.sv
// rtl/gpmc_phase_cnt.sv - loadable down-counter timing one bus phase, saturating at zero
module gpmc_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/gpmc_master.sv
// rtl/gpmc_master.sv - GPMC initiator: request handshake to multiplexed address/data bus cycles
module gpmc_master import gpmc_pkg::*; #(
    parameter int ADV_CYC  = GPMC_ADV_CYC,
    parameter int ACC_CYC  = GPMC_ACC_CYC,
    parameter int HOLD_CYC = GPMC_HOLD_CYC
) (
    input  logic               CLK_100M,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [GPMC_AW-1:0] req_addr,
    input  logic [GPMC_DW-1:0] req_wdata,
    output logic               rsp_valid,
    output logic [GPMC_DW-1:0] rsp_rdata,
    output logic [GPMC_DW-1:0] GPMC_AD_OUT,
    output logic               GPMC_AD_OE,
    input  logic [GPMC_DW-1:0] GPMC_AD_IN,
    output logic               GPMC_CSN,
    output logic               GPMC_ADVN,
    output logic               GPMC_WEN,
    output logic               GPMC_OEN,
    output logic               GPMC_CLK
);
    localparam int CW = $clog2(max3(ADV_CYC, ACC_CYC, HOLD_CYC)) + 1;

    gpmc_state_e        state_q;
    logic               req_ready_q, rsp_valid_q, we_q;
    logic [GPMC_DW-1:0] wdata_q, rdata_q, ad_out_q;
    logic               ad_oe_q, csn_q, advn_q, wen_q, oen_q, gclk_q;
    logic               cnt_load, cnt_zero;
    logic [CW-1:0]      cnt_val;

    // Counter is reloaded with the length-1 of whichever phase the FSM enters next.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(ADV_CYC - 1);
            end
            ADDR: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = we_q ? CW'(ACC_CYC - 1) : '0;
            end
            TURN: begin
                cnt_load = 1'b1;
                cnt_val  = CW'(ACC_CYC - 1);
            end
            DATA: if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(HOLD_CYC - 1);
            end
            default: ;
        endcase
    end

    gpmc_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk_i      (CLK_100M),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK_100M) begin
        if (RST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ad_out_q    <= '0;
            ad_oe_q     <= 1'b0;
            csn_q       <= 1'b1;
            advn_q      <= 1'b1;
            wen_q       <= 1'b1;
            oen_q       <= 1'b1;
            gclk_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q != IDLE) begin
                gclk_q <= ~gclk_q;
            end
            case (state_q)
                IDLE: if (req_valid && req_ready_q) begin
                    state_q     <= ADDR;
                    req_ready_q <= 1'b0;
                    we_q        <= req_we;
                    wdata_q     <= req_wdata;
                    csn_q       <= 1'b0;
                    advn_q      <= 1'b0;
                    ad_oe_q     <= 1'b1;
                    ad_out_q    <= req_addr;
                    gclk_q      <= 1'b1;
                end
                ADDR: if (cnt_zero) begin
                    advn_q <= 1'b1;
                    if (we_q) begin
                        state_q  <= DATA;
                        wen_q    <= 1'b0;
                        ad_out_q <= wdata_q;
                    end else begin
                        state_q <= TURN;
                        ad_oe_q <= 1'b0;
                    end
                end
                TURN: begin
                    state_q <= DATA;
                    oen_q   <= 1'b0;
                end
                DATA: if (cnt_zero) begin
                    state_q <= HOLD;
                    wen_q   <= 1'b1;
                    oen_q   <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= GPMC_AD_IN;
                    end
                end
                HOLD: if (cnt_zero) begin
                    state_q     <= IDLE;
                    csn_q       <= 1'b1;
                    ad_oe_q     <= 1'b0;
                    ad_out_q    <= '0;
                    gclk_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign GPMC_AD_OUT = ad_out_q;
    assign GPMC_AD_OE  = ad_oe_q;
    assign GPMC_CSN    = csn_q;
    assign GPMC_ADVN   = advn_q;
    assign GPMC_WEN    = wen_q;
    assign GPMC_OEN    = oen_q;
    assign GPMC_CLK    = gclk_q;
endmodule

// File: tb/tb_gpmc_master.sv
// tb/tb_gpmc_master.sv - scoreboard bench for gpmc_master with a behavioural bus memory
module tb_gpmc_master;
    localparam int ADV = 2, ACC = 4, HLD = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr, req_wdata, rsp_rdata, ad_out, ad_in;
    logic        ad_oe, csn, advn, wen, oen, gclk;

    logic        req_valid2, req_ready2, rsp_valid2;
    logic [15:0] rsp_rdata2, ad_out2, ad_in2;
    logic        ad_oe2, csn2, advn2, wen2, oen2, gclk2;

    gpmc_master #(.ADV_CYC(ADV), .ACC_CYC(ACC), .HOLD_CYC(HLD)) dut (
        .CLK_100M(clk), .RST(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .GPMC_AD_OUT(ad_out),
        .GPMC_AD_OE(ad_oe), .GPMC_AD_IN(ad_in), .GPMC_CSN(csn), .GPMC_ADVN(advn),
        .GPMC_WEN(wen), .GPMC_OEN(oen), .GPMC_CLK(gclk)
    );

    gpmc_master #(.ADV_CYC(1), .ACC_CYC(1), .HOLD_CYC(1)) dut_min (
        .CLK_100M(clk), .RST(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(1'b0), .req_addr(16'h0005), .req_wdata(16'h0000),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .GPMC_AD_OUT(ad_out2),
        .GPMC_AD_OE(ad_oe2), .GPMC_AD_IN(ad_in2), .GPMC_CSN(csn2), .GPMC_ADVN(advn2),
        .GPMC_WEN(wen2), .GPMC_OEN(oen2), .GPMC_CLK(gclk2)
    );
    assign ad_in2 = oen2 ? 16'h0000 : 16'hBEEF;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr, wdata, rdata;
        int          lat, acc_edge;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] ref_mem [16];
    logic [15:0] bus_mem [16];
    logic [15:0] last_rd;

    // Bus-side memory: latches the address phase, commits a write when WEN rises inside the cycle.
    logic [15:0] bus_addr = '0, bus_wd = '0;
    logic        wen_d = 1'b1;
    always @(posedge clk) begin
        #1;
        if (!csn && !advn) bus_addr = ad_out;
        if (!wen) bus_wd = ad_out;
        if (!csn && wen && !wen_d) bus_mem[bus_addr[3:0]] = bus_wd;
        wen_d = wen;
        ad_in = oen ? 16'($urandom) : bus_mem[bus_addr[3:0]];
    end

    int csn_len = 0, adv_len = 0, wen_len = 0, oen_len = 0;
    always @(negedge clk) begin
        exp_t e;
        chk("wen_oen_exclusive", 32'({wen, oen} != 2'b00), 32'd1);
        if (!csn) begin
            csn_len++;
            chk("gpmc_clk_toggle", 32'(gclk), 32'(csn_len % 2));
            if (exp_q.size() == 0) begin
                chk("csn_without_request", 32'(csn), 32'd1);
            end else begin
                e = exp_q[0];
                if (!advn) begin
                    adv_len++;
                    chk("addr_phase_oe", 32'(ad_oe), 32'd1);
                    chk("addr_phase_ad", 32'(ad_out), 32'(e.addr));
                end else if (e.we) begin
                    chk("write_oe", 32'(ad_oe), 32'd1);
                    chk("write_ad", 32'(ad_out), 32'(e.wdata));
                end else begin
                    chk("read_oe_off", 32'(ad_oe), 32'd0);
                end
                if (!wen) wen_len++;
                if (!oen) oen_len++;
            end
        end else begin
            chk("idle_ctl", 32'({advn, wen, oen, ad_oe, gclk}), 32'(5'b11100));
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_latency", 32'(cyc - e.acc_edge), 32'(e.lat));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("csn_len", 32'(csn_len), 32'(e.lat));
                chk("advn_len", 32'(adv_len), 32'(ADV));
                chk("wen_len", 32'(wen_len), e.we ? 32'(ACC) : 32'd0);
                chk("oen_len", 32'(oen_len), e.we ? 32'd0 : 32'(ACC));
            end
        end
        if (csn) begin
            csn_len = 0; adv_len = 0; wen_len = 0; oen_len = 0;
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d, output int waits);
        exp_t e;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        e.we = we; e.addr = a; e.wdata = d; e.acc_edge = cyc + 1;
        e.lat = ADV + ACC + HLD + (we ? 0 : 1);
        if (we) begin
            ref_mem[a[3:0]] = d;
            e.rdata = last_rd;
        end else begin
            e.rdata = ref_mem[a[3:0]];
            last_rd = e.rdata;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic idle_wait();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_ad_out"}, 32'(ad_out), 32'd0);
        chk({tag, "_bus_ctl"}, 32'({ad_oe, csn, advn, wen, oen, gclk}), 32'(6'b011110));
    endtask

    initial begin
        int w, n, t;
        logic [15:0] old;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'hC000 + 16'(i);
            bus_mem[i] = 16'hC000 + 16'(i);
        end
        ref_mem[1] = 16'h1234; bus_mem[1] = 16'h1234;
        last_rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        issue(1'b1, 16'h0003, 16'hA5C3, w);
        idle_wait();
        issue(1'b0, 16'h0001, 16'h0000, w);
        idle_wait();
        issue(1'b1, 16'h0000, 16'h000F, w);
        issue(1'b0, 16'h0000, 16'h0000, w);
        idle_wait();

        issue(1'b1, 16'h0002, 16'h1111, w);
        issue(1'b1, 16'h0006, 16'h2222, w);
        chk("b2b_accept_wait", 32'(w), 32'(ADV + ACC + HLD));
        issue(1'b1, 16'h0007, 16'h3333, w);
        chk("b2b_accept_wait", 32'(w), 32'(ADV + ACC + HLD));
        idle_wait();

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), 16'($urandom), 16'($urandom), w);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        idle_wait();

        old = ref_mem[4];
        issue(1'b1, 16'h0004, 16'hDEAD, w);
        n = 0; t = 0;
        while (n < 2 && t < 50) begin
            @(negedge clk);
            t++;
            if (!wen) n++;
        end
        chk("abort_reached_data2", 32'(n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        ref_mem[4] = old;
        last_rd = '0;
        @(negedge clk);
        chk_reset_outputs("abort");
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("abort_no_rsp", 32'(n), 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 16'h0004, 16'h0000, w);
        idle_wait();

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0007;
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("rst_wins_csn", 32'(csn), 32'd1);
        chk("rst_wins_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        req_valid2 = 1'b1;
        @(negedge clk);
        chk("min_ready", 32'(req_ready2), 32'd1);
        t = cyc + 1;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        n = 0; w = -1;
        for (int i = 0; i < 20 && w < 0; i++) begin
            @(negedge clk);
            if (!csn2) n++;
            if (rsp_valid2) w = cyc - t;
        end
        chk("min_csn_len", 32'(n), 32'd4);
        chk("min_rsp_latency", 32'(w), 32'd4);
        chk("min_rdata", 32'(rsp_rdata2), 32'hBEEF);
        chk("min_idle_clk", 32'({csn2, gclk2}), 32'(2'b10));

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
